// File: rtl/noc_out_arbiter.sv
// Per-output-port wormhole round-robin arbiter with credit-based flow control.
// Optional sticky credit-overflow flag enabled by defining NOC_ARB_CREDIT_CHECK_EN.
module noc_out_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IN-1:0]    req,
  input  logic [16*NUM_IN-1:0] in_data,
  input  logic [NUM_IN-1:0]    in_last,
  output logic [NUM_IN-1:0]    gnt,
  output logic                 out_enable,
  output logic [15:0]          out_data,
  input  logic                 credit,
  output logic                 credit_err
);

  localparam int              PW       = $clog2(NUM_IN);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NUM_IN - 1);
  localparam logic [3:0]      CMAX     = 4'(CREDITS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     owner, owner_n;
  logic [PW-1:0]     winner, cand;
  logic              found;
  logic [3:0]        cnt, cnt_n;
  logic [NUM_IN-1:0] gnt_v;
  logic              grant;
  logic [15:0]       gnt_data;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + PW'(1);
  endfunction

  // Round-robin search starting at ptr, wrapping modulo NUM_IN.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = ptr;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = next_idx(cand);
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    gnt_v   = '0;
    case (state)
      IDLE: begin
        if (cnt != '0 && found) begin
          gnt_v[winner] = 1'b1;
          if (in_last[winner]) begin
            ptr_n = next_idx(winner);
          end else begin
            owner_n = winner;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        // The link stays locked to the owner even while its request is low.
        if (cnt != '0 && req[owner]) begin
          gnt_v[owner] = 1'b1;
          if (in_last[owner]) begin
            ptr_n   = next_idx(owner);
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign gnt   = rst ? gnt_v : '0;
  assign grant = |gnt;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) gnt_data = in_data[16*i +: 16];
    end
  end

  // Credits saturate at CREDITS; a grant and a credit in one cycle cancel out.
  always_comb begin
    cnt_n = cnt;
    if (grant && !credit)
      cnt_n = cnt - 4'd1;
    else if (!grant && credit && cnt != CMAX)
      cnt_n = cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= CMAX;
      out_enable <= 1'b0;
      out_data   <= 16'h0000;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      owner      <= owner_n;
      cnt        <= cnt_n;
      out_enable <= grant;
      if (grant) out_data <= gnt_data;
    end
  end

`ifdef NOC_ARB_CREDIT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst)
      err_q <= 1'b0;
    else if (credit && !grant && cnt == CMAX)
      err_q <= 1'b1;
  end

  assign credit_err = err_q;
`else
  assign credit_err = 1'b0;
`endif

endmodule

// File: doc/noc_out_arbiter.md
# noc_out_arbiter

Per-output-port scheduler for a NoC router. It shares one outgoing router link among NUM_IN input buffers using wormhole, packet-locked round-robin arbitration. It enforces credit-based flow control toward the downstream router by tracking free downstream buffer slots. It drives the link's enable/data pair and consumes the link's credit return.

## Interface
- NUM_IN, 5, number of requesting input ports (N/S/E/W/local); range 2..8
- CREDITS, 4, downstream buffer depth in flits; initial and maximum credit count; range 1..15
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-low reset
- req  input  NUM_IN  input i holds a flit for this output
- in_data  input  16*NUM_IN  flit of input i in bits [16i+15:16i]
- in_last  input  NUM_IN  flit of input i is the packet tail
- gnt  output  NUM_IN  one-hot, combinational; input i's flit is consumed this cycle
- out_enable  output  1  registered; out_data valid this cycle
- out_data  output  16  registered flit to the downstream router
- credit  input  1  one-cycle pulse; downstream freed one slot
- credit_err  output  1  sticky; credit returned while the count was already CREDITS

## Operation
- Credit counter cnt is 4 bits wide.
  - Decrement by 1 on each grant.
  - Increment by 1 on each credit pulse.
  - Grant and credit in the same cycle leave cnt unchanged.
- Grant eligibility requires the registered cnt to be greater than 0. A credit arriving in the same cycle does not enable a grant in that cycle.
- State machine, 2 states:
  - IDLE:
    - If cnt > 0 and any req is set, grant the first set req searching ptr, ptr+1, …, wrapping mod NUM_IN.
    - If the granted flit has in_last set, stay in IDLE and set ptr = (winner+1) mod NUM_IN.
    - Otherwise latch owner = winner and go to BUSY.
  - BUSY:
    - Only the owner may be granted. Grant when req[owner] is set and cnt > 0.
    - No other input is granted while BUSY, even if the owner's req is low.
    - When a granted flit has in_last set, go to IDLE and set ptr = (owner+1) mod NUM_IN.
- gnt has at most one bit set. It is all-zero whenever rst is low or no grant is made.
- On a grant to input i: out_data <= in_data[i], out_enable <= 1 on the next edge. With no grant, out_enable <= 0 and out_data holds its value.
- Credit overflow (see Configuration): when credit arrives while cnt == CREDITS and there is no grant that cycle, cnt saturates at CREDITS.

## Timing
- Flit consumed (gnt high) in cycle N appears on out_enable/out_data in cycle N+1. Latency is 1.
- Throughput is 1 flit/cycle while cnt > 0 and the winner or owner keeps req high.
- A credit pulse in cycle N is usable for a grant from cycle N+1.
- Arbitration has no idle bubble:
  - A tail flit granted in cycle N can be followed by a head flit from another input in cycle N+1.
  - A single-flit packet (head is also tail) never enters BUSY.
- Reset values, applied when rst is low at an edge:
  - state = IDLE, ptr = 0, owner = 0, cnt = CREDITS.
  - out_enable = 0, out_data = 16'h0000, credit_err = 0, gnt = 0.
- Reset mid-packet abandons the packet. The arbiter restarts in IDLE with full credits.

## Configuration
- NOC_ARB_CREDIT_CHECK_EN defined:
  - credit_err goes high on the edge after a credit pulse that arrives while cnt == CREDITS with no grant in that cycle.
  - It stays high until reset.
- NOC_ARB_CREDIT_CHECK_EN undefined:
  - credit_err is tied to 0.
  - Overflow credits are silently saturated at CREDITS.

## Test plan
- **Single-flit round robin:** rst low 2 cycles, then NUM_IN=5, CREDITS=4, req=5'b11111, in_last all 1, credit pulsed every cycle. Required: gnt = 00001, 00010, 00100, 01000, 10000, 00001…, and out_enable high every cycle starting 1 cycle after the first grant.
- **Wormhole lock:** input 2 sends a 3-flit packet (16'hA001, A002, A003 last) while input 0 and input 4 req high. Required: gnt[2] for 3 consecutive cycles, then gnt[4]. Because ptr=3, input 4 wins over input 0.
- **Credit stall:** CREDITS=4, input 1 streams 6 flits with no credit return. Required:
  - 4 grants, then gnt=0 and out_enable=0 with cnt=0.
  - A credit pulse in cycle N gives a grant in cycle N+1, and out_data=5th flit in cycle N+2.
- **Owner bubble:** input 3 is mid-packet and drops req for 2 cycles while input 0 requests. Required: no grant to input 0 during those cycles. The packet resumes on input 3 when its req returns.
- **Simultaneous grant and credit at cnt=1:** required: grant occurs and cnt stays 1. A second flit is granted on the next cycle.
- **Overflow with macro defined:** credit pulse at reset state (cnt=4), no req. Required: credit_err=1 on the next cycle, held until rst low, and cnt remains 4. Without the macro, credit_err stays 0.
